// File: rtl/rv_buff_pkg.sv
// Shared types and constants for the buffer transfer engine.
// Imported by the engine, its address generator and its interface.
package rv_buff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } xfer_state_t;

  localparam logic DIR_M2B = 1'b0;
  localparam logic DIR_B2M = 1'b1;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 32;
  localparam int ADDR_STEP_DEF = 4;

endpackage

// File: rtl/buff_xfer_engine_if.sv
// Command, data-memory and buffer port bundle of the transfer engine.
// The engine uses the slave view; the command source and both memories use the master view.
interface buff_xfer_engine_if
  import rv_buff_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [ADDR_W-1:0] cmd_addr_mem;
  logic [ADDR_W-1:0] cmd_addr_buff;
  logic [31:0]       cmd_offset;

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              buff_re;
  logic              buff_we;
  logic [ADDR_W-1:0] buff_addr;
  logic [DATA_W-1:0] buff_wdata;
  logic [DATA_W-1:0] buff_rdata;

  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_dir, cmd_addr_mem, cmd_addr_buff, cmd_offset,
    input  mem_rdata, buff_rdata,
    output cmd_ready, mem_re, mem_we, mem_addr, mem_wdata,
    output buff_re, buff_we, buff_addr, buff_wdata, busy, done
  );

  modport master (
    output cmd_valid, cmd_dir, cmd_addr_mem, cmd_addr_buff, cmd_offset,
    output mem_rdata, buff_rdata,
    input  cmd_ready, mem_re, mem_we, mem_addr, mem_wdata,
    input  buff_re, buff_we, buff_addr, buff_wdata, busy, done
  );
endinterface

// File: rtl/buff_xfer_addr_gen.sv
// Source/destination address pointers for a burst, plus the destination
// pointer delayed one cycle to line up with the pipelined write.
module buff_xfer_addr_gen
  import rv_buff_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int ADDR_STEP = ADDR_STEP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic              dir,
  input  logic [ADDR_W-1:0] mem_base,
  input  logic [ADDR_W-1:0] buff_base,
  output logic [ADDR_W-1:0] src_ptr,
  output logic [ADDR_W-1:0] wr_ptr
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  logic [ADDR_W-1:0] dst_ptr;

  // Additions wrap naturally at 2^ADDR_W; low bits are carried unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      wr_ptr  <= '0;
    end else if (load) begin
      src_ptr <= (dir == DIR_B2M) ? buff_base : mem_base;
      dst_ptr <= (dir == DIR_B2M) ? mem_base  : buff_base;
    end else if (advance) begin
      src_ptr <= src_ptr + STEP;
      dst_ptr <= dst_ptr + STEP;
      wr_ptr  <= dst_ptr;
    end
  end
endmodule

// File: rtl/buff_xfer_engine.sv
// Burst mover between data memory and the internal buffer: one command moves
// offset+1 words, reads in RD, writes one cycle behind, then pulses done.
//
//   state | meaning
//   IDLE  | cmd_ready high, waiting for a command
//   RD    | one source read per cycle, write of the previous read alongside
//   DRAIN | no read, final write
//   DONE  | done pulse, no strobes
module buff_xfer_engine
  import rv_buff_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int ADDR_STEP = ADDR_STEP_DEF
) (
  input logic              clk,
  input logic              reset,
  buff_xfer_engine_if.slave bus
);
  xfer_state_t       state;
  logic              dir_q;
  logic [31:0]       remaining;
  logic              re_q;
  logic              we_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              load;
  logic              advance;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              mem_we_w;
  logic              buff_we_w;

  assign load    = (state == IDLE) && bus.cmd_valid;
  assign advance = (state == RD);

  buff_xfer_addr_gen #(
    .ADDR_W    (ADDR_W),
    .ADDR_STEP (ADDR_STEP)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .advance   (advance),
    .dir       (bus.cmd_dir),
    .mem_base  (bus.cmd_addr_mem),
    .buff_base (bus.cmd_addr_buff),
    .src_ptr   (src_ptr),
    .wr_ptr    (wr_ptr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dir_q     <= DIR_M2B;
      remaining <= '0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            dir_q     <= bus.cmd_dir;
            remaining <= bus.cmd_offset;
            re_q      <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
            state     <= RD;
          end
        end
        RD: begin
          we_q <= 1'b1;
          // Stop on zero rather than wrapping, so offset 0xFFFFFFFF is safe.
          if (remaining == 32'd0) begin
            re_q  <= 1'b0;
            state <= DRAIN;
          end else begin
            remaining <= remaining - 32'd1;
          end
        end
        DRAIN: begin
          we_q   <= 1'b0;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_we_w  = we_q && (dir_q == DIR_B2M);
  assign buff_we_w = we_q && (dir_q == DIR_M2B);

  assign bus.cmd_ready  = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.mem_re     = re_q && (dir_q == DIR_M2B);
  assign bus.buff_re    = re_q && (dir_q == DIR_B2M);
  assign bus.mem_we     = mem_we_w;
  assign bus.buff_we    = buff_we_w;
  assign bus.mem_addr   = (dir_q == DIR_B2M) ? wr_ptr : src_ptr;
  assign bus.buff_addr  = (dir_q == DIR_M2B) ? wr_ptr : src_ptr;
  // Write data is the source read data passed straight through, zero when idle.
  assign bus.mem_wdata  = mem_we_w  ? bus.buff_rdata : {DATA_W{1'b0}};
  assign bus.buff_wdata = buff_we_w ? bus.mem_rdata  : {DATA_W{1'b0}};
endmodule

// File: tb/tb_buff_xfer_engine.sv
// Directed bench for buff_xfer_engine: expected reads, writes and done pulses
// are queued when a command is issued and checked as the engine produces them.
module tb_buff_xfer_engine;
  import rv_buff_pkg::*;

  typedef struct {
    logic        is_mem;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  logic started;

  ev_t rd_q[$];
  ev_t wr_q[$];
  int  done_q[$];

  buff_xfer_engine_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  buff_xfer_engine #(.DATA_W(32), .ADDR_W(32), .ADDR_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] buff_word(input logic [31:0] a);
    return (a * 32'h85EBCA6B) ^ 32'hCAFE_0000;
  endfunction

  // Memories answer one cycle after a read strobe; anything else is junk.
  always @(posedge clk) begin
    bus.mem_rdata  <= bus.mem_re  ? mem_word(bus.mem_addr)   : 32'hDEAD_BEEF;
    bus.buff_rdata <= bus.buff_re ? buff_word(bus.buff_addr) : 32'hBAAD_F00D;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (started === 1'b1) begin
      chk("strobe_exclusive", {62'd0, bus.mem_re & bus.mem_we, bus.buff_re & bus.buff_we}, 64'd0);
      if (bus.mem_re || bus.buff_re) begin
        chk("rd_expected", 64'(rd_q.size() != 0), 64'd1);
        if (rd_q.size() != 0) begin
          e = rd_q.pop_front();
          chk("rd_side", {62'd0, bus.mem_re, bus.buff_re}, {62'd0, e.is_mem, ~e.is_mem});
          chk("rd_addr", 64'(e.is_mem ? bus.mem_addr : bus.buff_addr), 64'(e.addr));
          chk("rd_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (bus.mem_we || bus.buff_we) begin
        chk("wr_expected", 64'(wr_q.size() != 0), 64'd1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          chk("wr_side", {62'd0, bus.mem_we, bus.buff_we}, {62'd0, e.is_mem, ~e.is_mem});
          chk("wr_addr", 64'(e.is_mem ? bus.mem_addr : bus.buff_addr), 64'(e.addr));
          chk("wr_data", 64'(e.is_mem ? bus.mem_wdata : bus.buff_wdata), 64'(e.data));
          chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (bus.done) begin
        chk("done_expected", 64'(done_q.size() != 0), 64'd1);
        if (done_q.size() != 0) chk("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
    end
  end

  // Called at a negedge; leaves cmd_valid high and returns at the negedge of
  // the accept cycle t. cut>0 models a reset landing in cycle t+cut.
  task automatic issue(input logic d, input logic [31:0] ma, input logic [31:0] ba,
                       input logic [31:0] off, input int cut, output int t);
    int n;
    logic [31:0] src;
    logic [31:0] dst;
    ev_t e;
    n = int'(off) + 1;
    bus.cmd_dir       = d;
    bus.cmd_addr_mem  = ma;
    bus.cmd_addr_buff = ba;
    bus.cmd_offset    = off;
    bus.cmd_valid     = 1'b1;
    for (int k = 0; k < 50 && bus.cmd_ready !== 1'b1; k++) @(negedge clk);
    chk("accept_ready", {63'd0, bus.cmd_ready}, 64'd1);
    t = cyc;
    src = d ? ba : ma;
    dst = d ? ma : ba;
    for (int i = 0; i < n; i++) begin
      if (cut == 0 || i < cut) begin
        e.is_mem = ~d;
        e.addr   = src + 32'(4 * i);
        e.data   = 32'd0;
        e.cyc    = t + 1 + i;
        rd_q.push_back(e);
      end
      if (cut == 0 || i < cut - 1) begin
        e.is_mem = d;
        e.addr   = dst + 32'(4 * i);
        e.data   = d ? buff_word(src + 32'(4 * i)) : mem_word(src + 32'(4 * i));
        e.cyc    = t + 2 + i;
        wr_q.push_back(e);
      end
    end
    if (cut == 0) done_q.push_back(t + n + 2);
  endtask

  task automatic wait_idle(input int t, input int n);
    for (int k = 0; k < 200 && cyc < t + n + 2; k++) @(negedge clk);
    chk("done_cycle_reached", 64'(cyc), 64'(t + n + 2));
    chk("ready_busy_in_done", {62'd0, bus.cmd_ready, bus.busy}, 64'b01);
    @(negedge clk);
    chk("ready_busy_back", {62'd0, bus.cmd_ready, bus.busy}, 64'b10);
  endtask

  initial begin
    int ta;
    int tb;
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta;
    int tb;
    total = 0;
    bad = 0;
    started = 1'b0;
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_dir = 1'b0;
    bus.cmd_addr_mem = '0;
    bus.cmd_addr_buff = '0;
    bus.cmd_offset = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {60'd0, bus.cmd_ready, bus.busy, bus.done, 1'b0}, 64'b1000);
    chk("rst_strobes", {60'd0, bus.mem_re, bus.mem_we, bus.buff_re, bus.buff_we}, 64'd0);
    chk("rst_addrs", {bus.mem_addr, bus.buff_addr}, 64'd0);
    chk("rst_wdata", {bus.mem_wdata, bus.buff_wdata}, 64'd0);
    reset = 1'b0;
    started = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_quiet", {59'd0, bus.mem_re, bus.mem_we, bus.buff_re, bus.buff_we, bus.done}, 64'd0);
    end

    // memory to buffer, four words
    issue(DIR_M2B, 32'h100, 32'h20, 32'd3, 0, ta);
    @(negedge clk); bus.cmd_valid = 1'b0;
    wait_idle(ta, 4);

    // single word buffer to memory
    issue(DIR_B2M, 32'h200, 32'h40, 32'd0, 0, ta);
    @(negedge clk); bus.cmd_valid = 1'b0;
    wait_idle(ta, 1);

    // address wrap on both sides
    issue(DIR_M2B, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd1, 0, ta);
    @(negedge clk); bus.cmd_valid = 1'b0;
    wait_idle(ta, 2);

    // second command held on cmd_valid during a busy transfer
    issue(DIR_M2B, 32'h500, 32'h60, 32'd3, 0, ta);
    @(negedge clk);
    bus.cmd_dir = DIR_B2M;
    bus.cmd_addr_mem = 32'h600;
    bus.cmd_addr_buff = 32'h90;
    bus.cmd_offset = 32'd1;
    chk("held_not_ready", {63'd0, bus.cmd_ready}, 64'd0);
    issue(DIR_B2M, 32'h600, 32'h90, 32'd1, 0, tb);
    chk("held_accept_cycle", 64'(tb), 64'(ta + 7));
    @(negedge clk); bus.cmd_valid = 1'b0;
    wait_idle(tb, 2);

    // reset in cycle T+3 of an eight-word transfer
    issue(DIR_M2B, 32'h300, 32'h80, 32'd7, 3, ta);
    @(negedge clk); bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("post_rst_ctrl", {61'd0, bus.cmd_ready, bus.busy, bus.done}, 64'b100);
    chk("post_rst_strobes", {60'd0, bus.mem_re, bus.mem_we, bus.buff_re, bus.buff_we}, 64'd0);
    repeat (12) @(negedge clk);
    chk("post_rst_done_none", 64'(done_q.size()), 64'd0);

    // fresh command after the aborted one
    issue(DIR_B2M, 32'h700, 32'hA0, 32'd2, 0, ta);
    @(negedge clk); bus.cmd_valid = 1'b0;
    wait_idle(ta, 3);

    repeat (4) @(negedge clk);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
    chk("done_q_drained", 64'(done_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/buff_xfer_engine.md
# buff_xfer_engine

Executes the burst move between data memory and the internal buffer that the address buffer describes. It accepts one command (data-memory base, buffer base, offset), performs offset+1 word transfers with incrementing addresses, and signals completion. It is the consuming end of the address-buffer command stream and sits between that buffer, the data memory port and the internal buffer port of the RV32I core.

## Interface
- DATA_W, 32, word width of memory and buffer data
- ADDR_W, 32, address width of both address spaces
- ADDR_STEP, 4, byte increment per word on both address spaces
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle, command accepted when cmd_valid & cmd_ready
- cmd_dir  in  1  0 = memory→buffer (load), 1 = buffer→memory (store)
- cmd_addr_mem  in  ADDR_W  data-memory base byte address
- cmd_addr_buff  in  ADDR_W  buffer base byte address
- cmd_offset  in  32  word count minus 1
- mem_re  out  1  data-memory read strobe
- mem_we  out  1  data-memory write strobe
- mem_addr  out  ADDR_W  data-memory address
- mem_wdata  out  DATA_W  data-memory write data
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_re
- buff_re  out  1  buffer read strobe
- buff_we  out  1  buffer write strobe
- buff_addr  out  ADDR_W  buffer address
- buff_wdata  out  DATA_W  buffer write data
- buff_rdata  in  DATA_W  read data, valid exactly 1 cycle after buff_re
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE → RD → DRAIN → DONE → IDLE.
- IDLE: cmd_ready=1. On accept, latch dir, both bases and remaining=cmd_offset. Go to RD.
- RD: each cycle issue one read on the source side (mem_re if dir=0, buff_re if dir=1) at the current source address. Advance both address pointers by ADDR_STEP. If remaining==0, go to DRAIN, else decrement remaining.
- Write side is pipelined one cycle behind. Each read issued in cycle c produces a write in cycle c+1 at the destination address paired with that read. Write data is the source rdata passed through combinationally to mem_wdata/buff_wdata. Destination strobe is buff_we for dir=0 and mem_we for dir=1.
- DRAIN: no read. The final write occurs. Go to DONE.
- DONE: done=1, no strobes. Go to IDLE.
- Total transfers are exactly cmd_offset+1. offset=0 moves one word.
- Addresses wrap modulo 2^ADDR_W (0xFFFFFFFC+4 = 0x00000000). No alignment check; low bits are carried as given.
- remaining is 32 bits, so offset=0xFFFFFFFF is legal (2^32 words). It must not overflow.
- cmd_valid outside IDLE is ignored. The command is not queued, and cmd_ready stays 0.
- Strobes unused in the current direction are held 0. mem_re and mem_we are never high together, and buff_re and buff_we are never high together.

## Timing
- Reset values: state IDLE, cmd_ready=1, busy=0, done=0, all strobes 0, mem_addr/buff_addr/mem_wdata/buff_wdata=0.
- Command accepted in cycle T, with N = offset+1:
  - Reads occur in T+1..T+N.
  - Writes occur in T+2..T+N+1.
  - done is high in T+N+2.
  - cmd_ready is high again in T+N+3.
- The minimum command-to-command spacing is N+3 cycles.
- Reset asserted in any cycle: in the next cycle all strobes are 0 and the state is IDLE. The in-flight write is discarded and no done is issued.

## Structure
- Shared package rv_buff_pkg holds:
  - the state enum {IDLE, RD, DRAIN, DONE};
  - the direction constants DIR_M2B=0 and DIR_B2M=1;
  - the ADDR_STEP default.
- One sub-module, buff_xfer_addr_gen. It holds the source and destination pointers plus the one-cycle-delayed write pointer, with load, advance and wrap behaviour. It is instantiated once.

## Test plan
- dir=0, mem 0x100, buff 0x20, offset=3, memory holds word i at 0x100+4i: buffer writes occur at 0x20/0x24/0x28/0x2C with those words in T+2..T+5. done is high in T+6.
- offset=0, dir=1, buff 0x40, mem 0x200: exactly one buff_re in T+1 and one mem_we to 0x200 in T+2. done is high in T+3.
- Wrap case, dir=0, mem 0xFFFFFFFC, buff 0xFFFFFFFC, offset=1: second read and second write are both at 0x00000000.
- cmd_valid held high with a different command during a 4-word transfer: the second command is not started until cmd_ready=1 in T+7 and is accepted then. The first transfer is unaffected.
- reset asserted in T+3 of an offset=7 transfer: no strobes from T+4, and done never pulses. cmd_ready=1 in T+4. A fresh command then completes normally.
- After reset: all outputs are at their reset values, and no strobe is seen for 20 cycles with cmd_valid=0.
